// File: rtl/bcd_to_binary_pkg.sv
// rtl/bcd_to_binary_pkg.sv - shared FSM encodings and default sizes for bcd_to_binary
package bcd_to_binary_pkg;

  localparam int DEFAULT_DIGITS = 3;
  localparam int DEFAULT_BIN_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - per-digit correction step of reverse double dabble
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A set bit 3 after the shift came from the digit above and is worth 5, not 8.
  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential packed-BCD to binary converter (reverse double dabble)
// Optional macro BCD_RANGE_CHECK_EN: reject operands containing a digit above 9.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter int BIN_W  = DEFAULT_BIN_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  valid,
  output logic                  busy,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int WRK_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t             state, state_next;
  logic [WRK_W-1:0]   work, work_shift, work_adj;
  logic [CNT_W-1:0]   cnt;
  logic               load_err;
  logic               valid_next, busy_next;

  assign work_shift = work >> 1;
  assign work_adj[BIN_W-1:0] = work_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (work_shift[BIN_W + 4*g +: 4]),
      .dout (work_adj[BIN_W + 4*g +: 4])
    );
  end

`ifdef BCD_RANGE_CHECK_EN
  always_comb begin
    load_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) load_err = 1'b1;
    end
  end
`else
  assign load_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = load_err ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_ITER) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the state being entered.
  always_comb begin
    busy_next  = (state_next != ST_IDLE);
    valid_next = (state_next == ST_DONE) && (state != ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      work  <= '0;
      cnt   <= '0;
      bin   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      valid <= valid_next;
      busy  <= busy_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            work <= {bcd, {BIN_W{1'b0}}};
            cnt  <= '0;
            if (load_err) begin
              bin <= '0;
              err <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work <= work_adj;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            bin <= work_adj[BIN_W-1:0];
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - self-checking bench for bcd_to_binary (default and BCD_RANGE_CHECK_EN builds)
module tb_bcd_to_binary;

  localparam int BIN_W = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        valid, busy, err;

  int tests = 0;
  int fails = 0;

  bcd_to_binary dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .valid (valid),
    .busy  (busy),
    .err   (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [11:0] v);
    int r = 0;
    for (int i = 2; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic bit has_bad_digit(input logic [11:0] v);
    bit b = 0;
    for (int i = 0; i < 3; i++) if (v[4*i +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  // Behavioural model: a conversion is a fixed-latency job whose result is the decimal value.
  bit   m_ready = 0, m_active = 0;
  bit   m_valid = 0, m_err = 0;
  int   m_bin = 0, m_t = 0, m_total = 0, m_res = 0;
  bit   m_res_err = 0;

  task automatic model_latch();
    m_valid = 1;
    m_bin   = m_res;
    m_err   = m_res_err;
  endtask

  always @(posedge clock) begin
    m_valid = 0;
    if (reset) begin
      m_ready = 1; m_active = 0; m_bin = 0; m_err = 0; m_t = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active  = 1;
        m_t       = 0;
        m_res_err = 0;
        m_res     = dec(bcd) % (1 << BIN_W);
        m_total   = BIN_W;
`ifdef BCD_RANGE_CHECK_EN
        if (has_bad_digit(bcd)) begin
          m_res_err = 1; m_res = 0; m_total = 0;
        end
`endif
        if (m_t == m_total) model_latch();
      end
    end else begin
      m_t++;
      if (m_t == m_total) model_latch();
      else if (m_t > m_total) m_active = 0;
    end
  end

  always @(negedge clock) begin
    if (m_ready) begin
      check("cmp_valid", valid, m_valid);
      check("cmp_busy",  busy,  m_active);
      check("cmp_err",   err,   m_err);
      check("cmp_bin",   bin,   m_bin);
    end
  end

  // Called right after a negedge; start is seen at the next rising edge.
  task automatic run(input string nm, input logic [11:0] v, input int exp_bin,
                     input int exp_lat, input int exp_busy, input logic exp_err);
    int n, nb;
    start = 1; bcd = v;
    @(negedge clock);
    start = 0; bcd = 12'h777;
    n = 0; nb = 0;
    while (!valid && n < 40) begin
      if (busy) nb++;
      @(negedge clock); n++;
    end
    check({nm, "_latency"}, n, exp_lat);
    check({nm, "_bin"}, bin, exp_bin);
    check({nm, "_err"}, err, exp_err);
    while (busy && n < 60) begin
      nb++;
      @(negedge clock); n++;
    end
    check({nm, "_busy_cycles"}, nb, exp_busy);
  endtask

  initial begin
    int n, nv;
    reset = 1; start = 0; bcd = '0;

    check("model_999", dec(12'h999), 999);
    check("model_255", dec(12'h255), 255);
    check("model_042", dec(12'h042), 42);
    check("model_1a0", dec(12'h1A0), 200);

    repeat (3) @(negedge clock);
    check("rst_bin", bin, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    reset = 0;

    run("c999", 12'h999, 999, 10, 11, 1'b0);
    run("c000", 12'h000, 0,   10, 11, 1'b0);
    run("c255", 12'h255, 255, 10, 11, 1'b0);
    run("c001", 12'h001, 1,   10, 11, 1'b0);

    // Second start four edges into a conversion must be ignored.
    start = 1; bcd = 12'h456;
    @(negedge clock); start = 0;
    repeat (3) @(negedge clock);
    start = 1; bcd = 12'h123;
    @(negedge clock); start = 0;
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      if (valid) begin
        nv++;
        check("ignore_bin", bin, 456);
      end
      @(negedge clock);
    end
    check("ignore_valid_count", nv, 1);

    // Reset at start+5 aborts; a start is taken on the first edge after reset.
    start = 1; bcd = 12'h789;
    @(negedge clock); start = 0;
    nv = 0;
    repeat (4) begin
      if (valid) nv++;
      @(negedge clock);
    end
    reset = 1;
    @(negedge clock);
    check("abort_no_valid", nv, 0);
    check("abort_bin", bin, 0);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    reset = 0;
    run("c042", 12'h042, 42, 10, 11, 1'b0);

`ifdef BCD_RANGE_CHECK_EN
    // Rejected operand: valid appears in the cycle right after the start edge.
    run("bad1a0", 12'h1A0, 0, 0, 1, 1'b1);
`else
    run("bad1a0", 12'h1A0, 200, 10, 11, 1'b0);
`endif

    // Start held high: a new conversion every 12 edges.
    start = 1; bcd = 12'h321;
    n = 0;
    while (!valid && n < 40) begin @(negedge clock); n++; end
    check("b2b_first_seen", int'(valid), 1);
    @(negedge clock); n = 1;
    while (!valid && n < 40) begin @(negedge clock); n++; end
    check("b2b_period", n, 12);
    check("b2b_bin", bin, 321);
    start = 0;
    n = 0;
    while (busy && n < 40) begin @(negedge clock); n++; end
    check("b2b_drain", int'(busy), 0);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameter DIGITS, default 3, sets the number of packed BCD input digits.
REQ-002 Parameter BIN_W, default 10, sets the binary result width; BIN_W >= ceil(log2(10^DIGITS)).
REQ-003 Port clock, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 Port bcd, input, 4*DIGITS bits: packed BCD operand, least significant digit in [3:0].
REQ-007 Port bin, output, BIN_W bits: registered binary result.
REQ-008 Port valid, output, 1 bit: one-cycle pulse marking a new bin value.
REQ-009 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 Port err, output, 1 bit: invalid-digit flag, qualified by valid.
REQ-011 One clock; reset is synchronous and active-high; ports are named clock and reset.

Function
REQ-012 Algorithm: reverse double dabble on a (4*DIGITS+BIN_W)-bit work register W = {digits, result}, one iteration per clock.
REQ-013 Iteration order: first shift W right by 1; then, per digit field of the upper 4*DIGITS bits, if the digit is >= 8, subtract 3.
REQ-014 FSM states: IDLE, SHIFT, DONE; no other states are reachable.
REQ-015 IDLE with start=1 at edge k: load W = {bcd, BIN_W'b0}, clear the iteration counter, go to SHIFT; busy is high from k+1.
REQ-016 SHIFT: one iteration per edge; after exactly BIN_W iterations (edge k+BIN_W), latch bin = W[BIN_W-1:0] and go to DONE.
REQ-017 DONE: valid=1 for exactly one cycle, then return to IDLE; latency from start edge to valid = BIN_W cycles (10 at default).
REQ-018 start is ignored while busy=1, including during DONE; there is no queueing and no effect on the running conversion.
REQ-019 bcd is sampled only at the load edge; later changes to bcd do not affect the running conversion.
REQ-020 bin holds its last value between valid pulses; err changes only at a result latch.
REQ-021 The iteration counter is $clog2(BIN_W+1) bits wide and never wraps within a conversion.
REQ-022 For every valid input, the result is exact; the all-nines input yields 10^DIGITS-1.

Reset
REQ-023 reset=1 at any edge forces state IDLE, bin=0, valid=0, busy=0, err=0, counter=0, W=0.
REQ-024 reset overrides start on the same edge; reset during SHIFT or DONE aborts the conversion with no valid pulse.
REQ-025 The first start is accepted on the first edge after reset deasserts.

Configuration
REQ-026 Macro BCD_RANGE_CHECK_EN defined: at load, if any input digit is > 9, skip SHIFT, go straight to DONE with bin=0 and err=1 (valid one cycle after the start edge).
REQ-027 Macro BCD_RANGE_CHECK_EN undefined: no digit check; err is tied 0; every input runs the full BIN_W-iteration algorithm unchanged.

Structure
REQ-028 A shared definitions header holds the FSM state encodings and the DIGITS/BIN_W default constants.
REQ-029 Sub-module bcd_digit_adjust (4-bit in/out, combinational ">=8 subtract 3") is instantiated DIGITS times via generate.
REQ-030 All sequential logic is one clocked block in bcd_to_binary; outputs are driven from registers only.

Verification
REQ-031 bcd=0x999, start pulse -> busy high for 11 cycles; valid at start+10; bin=999 (0x3E7); err=0.
REQ-032 bcd=0x000 -> bin=0 at start+10; bcd=0x255 -> bin=255; bcd=0x001 -> bin=1.
REQ-033 Second start pulse at start+4 with bcd=0x123, first conversion 0x456 -> exactly one valid, bin=456; the second start is ignored.
REQ-034 reset asserted at start+5 -> no valid pulse; all outputs 0 next cycle; new start with 0x042 -> bin=42 after 10 cycles.
REQ-035 BCD_RANGE_CHECK_EN defined, bcd=0x1A0 -> valid at start+1, err=1, bin=0; macro undefined -> err stays 0 and valid at start+10.
REQ-036 Back-to-back: start held high continuously -> conversions restart each IDLE, with valid every 12 cycles.
